// File: rtl/i2c_master_pkg.sv
// Shared definitions for the byte-level I2C master: state encoding,
// default field widths and the width of the per-bit down-counter.
package i2c_master_pkg;

  localparam int unsigned ADDR_W_DEF = 7;
  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned BIT_CNT_W  = 4;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WRITE,
    ST_WRITE_ACK,
    ST_READ,
    ST_READ_ACK,
    ST_STOP
  } state_e;

endpackage

// File: rtl/i2c_edge_tick_decoder.sv
// Decodes the clock generator's edge-detect counter into two strobes that
// land in the middle of the SCL-low and SCL-high phases. Data changes on
// low_tick and is sampled on high_tick, so SDA never moves near an SCL edge.
module i2c_edge_tick_decoder (
  input  logic [7:0] prescaler,
  input  logic       scl,
  input  logic [7:0] counter_detect_edge,
  output logic       low_tick,
  output logic       high_tick
);

  logic [7:0] mid;
  logic [7:0] mid_hi;
  logic       at_mid;

  // Mid-phase positions of the counter for the low half and the high half.
  always_comb begin
    mid       = prescaler >> 1;
    mid_hi    = prescaler + mid;
    at_mid    = (counter_detect_edge == mid) || (counter_detect_edge == mid_hi);
    low_tick  = at_mid && !scl;
    high_tick = at_mid && scl;
  end

endmodule

// File: rtl/i2c_master_byte_fsm.sv
// Single-byte I2C master transaction engine: START, address + R/W,
// one data byte written or read, ACK handling, STOP. SCL itself comes from
// an external clock generator that this block only enables.
module i2c_master_byte_fsm
  import i2c_master_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              i2c_core_clock_i,
  input  logic              reset_bit_i,
  input  logic [7:0]        prescaler_i,
  input  logic              scl_i,
  input  logic [7:0]        counter_detect_edge_i,
  output logic              scl_en_o,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_rw_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [DATA_W-1:0] cmd_wdata_i,
  input  logic              sda_i,
  output logic              sda_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              done_o,
  output logic              ack_error_o,
  output logic              busy_o
);

  state_e                 state;
  logic                   rw_q;
  logic [ADDR_W:0]        addr_rw_q;
  logic [DATA_W-1:0]      wdata_q;
  logic [DATA_W-1:0]      rd_shift_q;
  logic [BIT_CNT_W-1:0]   bit_cnt_q;
  logic                   low_tick;
  logic                   high_tick;

  i2c_edge_tick_decoder u_tick (
    .prescaler           (prescaler_i),
    .scl                 (scl_i),
    .counter_detect_edge (counter_detect_edge_i),
    .low_tick            (low_tick),
    .high_tick           (high_tick)
  );

  // Transaction sequencer; every output is a register written here.
  // NOTE: all state and outputs use <= so every branch sees the values from
  // before this edge, exactly as the flops behave.
  always_ff @(posedge i2c_core_clock_i) begin
    if (reset_bit_i) begin
      state       <= ST_IDLE;
      sda_o       <= 1'b1;
      scl_en_o    <= 1'b0;
      cmd_ready_o <= 1'b1;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      ack_error_o <= 1'b0;
      rdata_o     <= '0;
      bit_cnt_q   <= '0;
      rw_q        <= 1'b0;
      addr_rw_q   <= '0;
      wdata_q     <= '0;
      rd_shift_q  <= '0;
    end else begin
      // NOTE: done_o defaults low every cycle so the STOP branch yields a
      // single-cycle pulse without a separate clear path.
      done_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid_i && cmd_ready_o) begin
            rw_q        <= cmd_rw_i;
            addr_rw_q   <= {cmd_addr_i, cmd_rw_i};
            wdata_q     <= cmd_wdata_i;
            cmd_ready_o <= 1'b0;
            busy_o      <= 1'b1;
            scl_en_o    <= 1'b1;
            ack_error_o <= 1'b0;
            state       <= ST_START;
          end
        end
        ST_START: begin
          // SDA falls while SCL is high: START condition.
          if (high_tick) begin
            sda_o     <= 1'b0;
            bit_cnt_q <= BIT_CNT_W'(ADDR_W);
            state     <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (low_tick) begin
            sda_o <= addr_rw_q[bit_cnt_q];
          end else if (high_tick) begin
            if (bit_cnt_q == '0) state <= ST_ADDR_ACK;
            else                 bit_cnt_q <= bit_cnt_q - 1'b1;
          end
        end
        ST_ADDR_ACK: begin
          if (low_tick) begin
            sda_o <= 1'b1;
          end else if (high_tick) begin
            if (sda_i) begin
              ack_error_o <= 1'b1;
              state       <= ST_STOP;
            end else begin
              bit_cnt_q <= BIT_CNT_W'(DATA_W - 1);
              state     <= rw_q ? ST_READ : ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          if (low_tick) begin
            sda_o <= wdata_q[bit_cnt_q];
          end else if (high_tick) begin
            if (bit_cnt_q == '0) state <= ST_WRITE_ACK;
            else                 bit_cnt_q <= bit_cnt_q - 1'b1;
          end
        end
        ST_WRITE_ACK: begin
          if (low_tick) begin
            sda_o <= 1'b1;
          end else if (high_tick) begin
            if (sda_i) ack_error_o <= 1'b1;
            state <= ST_STOP;
          end
        end
        ST_READ: begin
          if (low_tick) begin
            sda_o <= 1'b1;
          end else if (high_tick) begin
            rd_shift_q <= {rd_shift_q[DATA_W-2:0], sda_i};
            if (bit_cnt_q == '0) state <= ST_READ_ACK;
            else                 bit_cnt_q <= bit_cnt_q - 1'b1;
          end
        end
        ST_READ_ACK: begin
          // Master NACK: leave SDA released for the whole ninth bit.
          if (low_tick) begin
            sda_o <= 1'b1;
          end else if (high_tick) begin
            state <= ST_STOP;
          end
        end
        ST_STOP: begin
          // SDA low during SCL low, then rises while SCL is high: STOP.
          if (low_tick) begin
            sda_o <= 1'b0;
          end else if (high_tick) begin
            sda_o       <= 1'b1;
            scl_en_o    <= 1'b0;
            done_o      <= 1'b1;
            busy_o      <= 1'b0;
            cmd_ready_o <= 1'b1;
            bit_cnt_q   <= '0;
            if (rw_q && !ack_error_o) rdata_o <= rd_shift_q;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_master_byte_fsm.sv
// Directed bench for i2c_master_byte_fsm with a behavioural SCL clock
// generator, a bit-slot slave and a capture of SDA at every SCL-high midpoint.
module tb_i2c_master_byte_fsm;

  logic       clk = 1'b0;
  logic       reset_bit_i = 1'b1;
  logic [7:0] prescaler = 8'd4;
  logic [7:0] cnt = 8'd0;
  logic       scl;
  logic       scl_en_o;
  logic       cmd_valid_i = 1'b0;
  logic       cmd_ready_o;
  logic       cmd_rw_i = 1'b0;
  logic [6:0] cmd_addr_i = '0;
  logic [7:0] cmd_wdata_i = '0;
  logic       sda_i;
  logic       sda_o;
  logic [7:0] rdata_o;
  logic       done_o;
  logic       ack_error_o;
  logic       busy_o;

  int tests = 0;
  int fails = 0;

  // Capture / slave model state
  logic [63:0] cap = '0;
  int unsigned cap_cnt = 0;
  int unsigned base = 0;
  int unsigned hi_changes = 0;
  logic        prev_scl = 1'b1;
  logic        prev_sda = 1'b1;
  logic        slave_drive = 1'b1;
  logic        txn_rw = 1'b0;
  logic        slave_addr_ack = 1'b1;
  logic [7:0]  slave_rbyte = '0;

  always #5 clk = ~clk;

  // Clock generator: counter runs 2P-1..0, SCL high in the upper half.
  assign scl = (cnt >= prescaler);
  always @(posedge clk) begin
    if (!scl_en_o) cnt <= (prescaler << 1) - 8'd1;
    else if (cnt == 8'd0) cnt <= (prescaler << 1) - 8'd1;
    else cnt <= cnt - 8'd1;
  end

  // Open-drain bus seen by the master.
  assign sda_i = sda_o & slave_drive;

  i2c_master_byte_fsm dut (
    .i2c_core_clock_i      (clk),
    .reset_bit_i           (reset_bit_i),
    .prescaler_i           (prescaler),
    .scl_i                 (scl),
    .counter_detect_edge_i (cnt),
    .scl_en_o              (scl_en_o),
    .cmd_valid_i           (cmd_valid_i),
    .cmd_ready_o           (cmd_ready_o),
    .cmd_rw_i              (cmd_rw_i),
    .cmd_addr_i            (cmd_addr_i),
    .cmd_wdata_i           (cmd_wdata_i),
    .sda_i                 (sda_i),
    .sda_o                 (sda_o),
    .rdata_o               (rdata_o),
    .done_o                (done_o),
    .ack_error_o           (ack_error_o),
    .busy_o                (busy_o)
  );

  // Slot 0 = START, 1..8 address byte, 9 address ACK, 10..17 data, 18 data ACK.
  function automatic logic slave_value(input int unsigned slot);
    if (slot == 9) return slave_addr_ack ? 1'b0 : 1'b1;
    if (txn_rw && slot >= 10 && slot <= 17) return slave_rbyte[17 - slot];
    if (!txn_rw && slot == 18) return 1'b0;
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    logic [7:0] mid;
    mid = prescaler >> 1;
    if (scl_en_o && scl && cnt == prescaler + mid) begin
      cap = {cap[62:0], sda_o};
      cap_cnt++;
    end
    if (scl_en_o && !scl && cnt == mid) slave_drive = slave_value(cap_cnt - base);
    if (scl && prev_scl && sda_o !== prev_sda) hi_changes++;
    prev_scl = scl;
    prev_sda = sda_o;
  end

  // Called just after a negedge; returns at the negedge after the accept edge.
  task automatic start_cmd(input logic rw, input logic [6:0] addr, input logic [7:0] wd,
                           input logic ack, input logic [7:0] rb, input bit hold);
    txn_rw = rw; slave_addr_ack = ack; slave_rbyte = rb;
    base = cap_cnt;
    cmd_rw_i = rw; cmd_addr_i = addr; cmd_wdata_i = wd; cmd_valid_i = 1'b1;
    @(negedge clk);
    if (!hold) cmd_valid_i = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done_o === 1'b1) begin got = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset_bit_i = 1'b1;
    repeat (3) @(negedge clk);
    reset_bit_i = 1'b0;
    tests++;
    if ({sda_o, scl_en_o, cmd_ready_o, busy_o, done_o, ack_error_o} !== 6'b101000) begin
      fails++; $display("FAIL reset_ctrl: got %b expected 101000",
                        {sda_o, scl_en_o, cmd_ready_o, busy_o, done_o, ack_error_o});
    end
    tests++;
    if (rdata_o !== 8'h00) begin fails++; $display("FAIL reset_rdata: got %h expected 00", rdata_o); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write;
    bit got;
    prescaler = 8'd4; repeat (2) @(negedge clk);
    start_cmd(1'b0, 7'h50, 8'hA5, 1'b1, 8'h00, 1'b0);
    tests++;
    if ({busy_o, cmd_ready_o, scl_en_o} !== 3'b101) begin
      fails++; $display("FAIL wr_accept: got %b expected 101", {busy_o, cmd_ready_o, scl_en_o});
    end
    wait_done(1000, got);
    tests++;
    if (!got) begin fails++; $display("FAIL wr_done_timeout: got no done expected done"); end
    tests++;
    if (ack_error_o !== 1'b0) begin fails++; $display("FAIL wr_ack_err: got %b expected 0", ack_error_o); end
    tests++;
    if (cap_cnt - base != 20) begin fails++; $display("FAIL wr_bit_count: got %0d expected 20", cap_cnt - base); end
    tests++;
    if (cap[19:0] !== 20'b1_10100000_1_10100101_1_0) begin
      fails++; $display("FAIL wr_bits: got %b expected %b", cap[19:0], 20'b1_10100000_1_10100101_1_0);
    end
    @(negedge clk);
    tests++;
    if ({done_o, busy_o, sda_o} !== 3'b001) begin
      fails++; $display("FAIL wr_after_done: got %b expected 001", {done_o, busy_o, sda_o});
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_addr_nack;
    bit got;
    start_cmd(1'b0, 7'h27, 8'h5A, 1'b0, 8'h00, 1'b0);
    wait_done(1000, got);
    tests++;
    if (!got) begin fails++; $display("FAIL nack_done_timeout: got no done expected done"); end
    tests++;
    if (ack_error_o !== 1'b1) begin fails++; $display("FAIL nack_ack_err: got %b expected 1", ack_error_o); end
    tests++;
    if (cap_cnt - base != 11) begin fails++; $display("FAIL nack_bit_count: got %0d expected 11", cap_cnt - base); end
    tests++;
    if (cap[10:0] !== 11'b1_01001110_1_0) begin
      fails++; $display("FAIL nack_bits: got %b expected %b", cap[10:0], 11'b1_01001110_1_0);
    end
    tests++;
    if (rdata_o !== 8'h00) begin fails++; $display("FAIL nack_rdata_hold: got %h expected 00", rdata_o); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_read;
    bit got;
    start_cmd(1'b1, 7'h3C, 8'h00, 1'b1, 8'h96, 1'b0);
    wait_done(1000, got);
    tests++;
    if (!got) begin fails++; $display("FAIL rd_done_timeout: got no done expected done"); end
    tests++;
    if (rdata_o !== 8'h96) begin fails++; $display("FAIL rd_rdata: got %h expected 96", rdata_o); end
    tests++;
    if (ack_error_o !== 1'b0) begin fails++; $display("FAIL rd_ack_err: got %b expected 0", ack_error_o); end
    tests++;
    if (cap[19:0] !== 20'b1_01111001_1_11111111_1_0 || cap_cnt - base != 20) begin
      fails++; $display("FAIL rd_bits: got %b (%0d) expected %b (20)", cap[19:0], cap_cnt - base,
                        20'b1_01111001_1_11111111_1_0);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_back_to_back;
    bit got;
    start_cmd(1'b0, 7'h11, 8'h3C, 1'b1, 8'h00, 1'b1);
    cmd_addr_i = 7'h22; cmd_wdata_i = 8'hC3;
    wait_done(1000, got);
    tests++;
    if (!got) begin fails++; $display("FAIL b2b_done1_timeout: got no done expected done"); end
    tests++;
    if ({busy_o, cmd_ready_o} !== 2'b01) begin
      fails++; $display("FAIL b2b_gap: got busy,ready=%b expected 01", {busy_o, cmd_ready_o});
    end
    tests++;
    if (rdata_o !== 8'h96) begin fails++; $display("FAIL b2b_rdata_hold: got %h expected 96", rdata_o); end
    tests++;
    if (cap[19:0] !== 20'b1_00100010_1_00111100_1_0 || cap_cnt - base != 20) begin
      fails++; $display("FAIL b2b_bits1: got %b (%0d) expected %b (20)", cap[19:0], cap_cnt - base,
                        20'b1_00100010_1_00111100_1_0);
    end
    base = cap_cnt;
    @(negedge clk);
    cmd_valid_i = 1'b0;
    tests++;
    if ({busy_o, cmd_ready_o, scl_en_o} !== 3'b101) begin
      fails++; $display("FAIL b2b_restart: got %b expected 101", {busy_o, cmd_ready_o, scl_en_o});
    end
    wait_done(1000, got);
    tests++;
    if (!got || ack_error_o !== 1'b0) begin
      fails++; $display("FAIL b2b_done2: got done=%b ack_err=%b expected 1 0", got, ack_error_o);
    end
    tests++;
    if (cap[19:0] !== 20'b1_01000100_1_11000011_1_0 || cap_cnt - base != 20) begin
      fails++; $display("FAIL b2b_bits2: got %b (%0d) expected %b (20)", cap[19:0], cap_cnt - base,
                        20'b1_01000100_1_11000011_1_0);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_min_prescaler;
    bit got;
    int unsigned hc0;
    prescaler = 8'd2; repeat (3) @(negedge clk);
    hc0 = hi_changes;
    start_cmd(1'b0, 7'h12, 8'hFF, 1'b1, 8'h00, 1'b0);
    wait_done(1000, got);
    tests++;
    if (!got || ack_error_o !== 1'b0) begin
      fails++; $display("FAIL p2_done: got done=%b ack_err=%b expected 1 0", got, ack_error_o);
    end
    tests++;
    if (cap[19:0] !== 20'b1_00100100_1_11111111_1_0 || cap_cnt - base != 20) begin
      fails++; $display("FAIL p2_bits: got %b (%0d) expected %b (20)", cap[19:0], cap_cnt - base,
                        20'b1_00100100_1_11111111_1_0);
    end
    repeat (3) @(negedge clk);
    tests++;
    if (hi_changes - hc0 != 2) begin
      fails++; $display("FAIL p2_sda_high_changes: got %0d expected 2", hi_changes - hc0);
    end
  endtask

  task automatic test_reset_mid;
    bit hit;
    bit stray;
    prescaler = 8'd4; repeat (3) @(negedge clk);
    start_cmd(1'b0, 7'h50, 8'hB5, 1'b1, 8'h00, 1'b0);
    hit = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (cap_cnt - base == 14 && sda_o === 1'b0) begin hit = 1'b1; break; end
      @(negedge clk);
    end
    tests++;
    if (!hit) begin fails++; $display("FAIL rst_mid_reach_bit3: got no bit3 expected bit3"); end
    reset_bit_i = 1'b1;
    @(negedge clk);
    reset_bit_i = 1'b0;
    tests++;
    if ({sda_o, scl_en_o, cmd_ready_o, busy_o, done_o, ack_error_o} !== 6'b101000) begin
      fails++; $display("FAIL rst_mid_ctrl: got %b expected 101000",
                        {sda_o, scl_en_o, cmd_ready_o, busy_o, done_o, ack_error_o});
    end
    tests++;
    if (rdata_o !== 8'h00) begin fails++; $display("FAIL rst_mid_rdata: got %h expected 00", rdata_o); end
    stray = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (sda_o !== 1'b1 || done_o !== 1'b0 || scl_en_o !== 1'b0) stray = 1'b1;
    end
    tests++;
    if (stray) begin fails++; $display("FAIL rst_mid_no_stop: got bus activity expected idle"); end
  endtask

  initial begin
    test_reset;
    test_write;
    test_addr_nack;
    test_read;
    test_back_to_back;
    test_min_prescaler;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/i2c_master_byte_fsm.md
I2C_MASTER_BYTE_FSM -- requirements
Module: i2c_master_byte_fsm

Interface
REQ-001 SHALL have parameter ADDR_W, default 7, slave address width.
REQ-002 SHALL have parameter DATA_W, default 8, data byte width.
REQ-003 SHALL have port i2c_core_clock_i  in  1  i2c core clock; the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset_bit_i  in  1  reset; synchronous, active-high.
REQ-005 SHALL have port prescaler_i  in  8  prescaler value shared with the clock generator; legal range 2..127.
REQ-006 SHALL have port scl_i  in  1  SCL level from the clock generator.
REQ-007 SHALL have port counter_detect_edge_i  in  8  edge-detect counter from the clock generator, counting 2*prescaler-1 down to 0.
REQ-008 SHALL have port scl_en_o  out  1  enables the SCL output of the clock generator.
REQ-009 SHALL have port cmd_valid_i  in  1  command request.
REQ-010 SHALL have port cmd_ready_o  out  1  command accepted when cmd_valid_i and cmd_ready_o are both high.
REQ-011 SHALL have port cmd_rw_i  in  1  0 = write, 1 = read.
REQ-012 SHALL have port cmd_addr_i  in  ADDR_W  slave address.
REQ-013 SHALL have port cmd_wdata_i  in  DATA_W  write byte.
REQ-014 SHALL have port sda_i  in  1  sampled SDA line.
REQ-015 SHALL have port sda_o  out  1  SDA drive value; 0 = pull low, 1 = release.
REQ-016 SHALL have port rdata_o  out  DATA_W  read byte.
REQ-017 SHALL have port done_o  out  1  one-cycle pulse at end of transaction.
REQ-018 SHALL have port ack_error_o  out  1  NACK seen; valid with done_o.
REQ-019 SHALL have port busy_o  out  1  high from command accept until STOP completes.

Function
REQ-020 SHALL define mid = prescaler_i>>1, low_tick = scl_i==0 and counter_detect_edge_i in {mid, prescaler_i+mid}, and high_tick = the same counter condition with scl_i==1.
REQ-021 SHALL implement states IDLE, START, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, STOP.
REQ-022 SHALL hold cmd_ready_o=1 only in IDLE, and on accept SHALL latch rw, addr and wdata, and go to START with scl_en_o=1.
REQ-023 SHALL, in START, drive sda_o=0 at the first high_tick, then go to ADDR.
REQ-024 SHALL, in ADDR, shift {addr, rw} MSB-first, changing sda_o only on low_tick, using a 4-bit bit counter loaded to ADDR_W and decremented per bit.
REQ-025 SHALL, in ADDR_ACK and WRITE_ACK, release sda_o on low_tick and sample sda_i on high_tick; sda_i=1 SHALL set ack_error and go to STOP.
REQ-026 SHALL, after an ACK on the address, go to WRITE if rw=0 and READ if rw=1.
REQ-027 SHALL, in WRITE, shift wdata MSB-first on low_tick for DATA_W bits, then go to WRITE_ACK.
REQ-028 SHALL, in READ, release sda_o and shift sda_i into rdata MSB-first on each high_tick for DATA_W bits.
REQ-029 SHALL, in READ_ACK, drive sda_o=1 (master NACK) for one bit time, then go to STOP.
REQ-030 SHALL, in STOP, drive sda_o=0 on low_tick and sda_o=1 on the next high_tick, then deassert scl_en_o, pulse done_o and return to IDLE.
REQ-031 SHALL update rdata_o only with done_o of a successful read, and SHALL hold it otherwise.
REQ-032 SHALL handle cmd_valid_i held high at done_o by accepting it on the first cycle back in IDLE.
REQ-033 SHALL treat a prescaler_i change during busy_o as unsupported, with behaviour undefined.

Reset
REQ-034 SHALL, on reset_bit_i=1 at a clock edge, force state IDLE, sda_o=1, scl_en_o=0, cmd_ready_o=1, busy_o=0, done_o=0, ack_error_o=0, rdata_o=0 and bit counter 0, including mid-transaction, with no STOP generated.

Structure
REQ-035 SHALL place the state encoding, ADDR_W/DATA_W defaults and the bit-counter width in shared package i2c_master_pkg.
REQ-036 SHALL implement the REQ-020 tick decode in sub-module i2c_edge_tick_decoder.

Verification
REQ-037 SHALL cover: prescaler 4, write addr 0x50 data 0xA5, slave ACKs -> SDA bits 1010000 0, then 10100101; done_o=1, ack_error_o=0.
REQ-038 SHALL cover: write to addr 0x27 with SDA high in ADDR_ACK -> ack_error_o=1 with done_o, no WRITE bits, STOP issued.
REQ-039 SHALL cover: read addr 0x3C, slave drives 0x96 -> rdata_o=0x96 at done_o, master NACK bit 1.
REQ-040 SHALL cover: reset_bit_i pulsed in WRITE bit 3 -> next cycle sda_o=1, scl_en_o=0, IDLE.
REQ-041 SHALL cover: cmd_valid_i held across two commands -> second START begins right after the first done_o, busy_o drops for exactly one cycle.
REQ-042 SHALL cover: prescaler 2 (minimum) write 0xFF -> correct bit order, sda_o stable during every SCL-high phase except START and STOP.
